// File: rtl/uart_rx_in_mod_pkg.sv
// Shared types and derived constants for the UART receiver.
// The state enum, baud arithmetic and majority helper live here so the top stays focused on sequencing.
package uart_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  function automatic int calc_baud_count(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int calc_half_count(input int clock_freq, input int baud_rate);
    return calc_baud_count(clock_freq, baud_rate) / 2;
  endfunction

  // Two-of-three vote used when the mid-bit decision is glitch filtered.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_in_mod_if.sv
// Serial line plus received-byte outputs of the UART receiver.
// slave is the receiver side, master is the line driver / byte consumer side.
interface uart_rx_in_mod_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  modport slave (
    input  rx,
    output data,
    output valid,
    output framing_err,
    output busy
  );

  modport master (
    output rx,
    input  data,
    input  valid,
    input  framing_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_in_mod_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look like a start edge after reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_in_mod.sv
// 8N1 UART receiver: synchronizes rx, recovers frames and pulses valid / framing_err for one cycle.
// Define UART_RX_MAJORITY_EN to take each mid-bit decision as a 2-of-3 vote around the mid point.
module uart_rx_in_mod
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 100_000_000
) (
  input logic            clk,
  input logic            rst,
  uart_rx_in_mod_if.slave bus
);

  localparam int BAUD_COUNT = calc_baud_count(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_COUNT = calc_half_count(CLOCK_FREQ, BAUD_RATE);
  localparam int CW         = $clog2(BAUD_COUNT);
  localparam int IDX_W      = $clog2(FRAME_BITS);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_OFS = 1;
`else
  localparam int SAMPLE_OFS = 0;
`endif

  // Offsetting only the start decision shifts every later decision by the same single cycle.
  localparam logic [CW-1:0]    C_START_DEC = CW'(HALF_COUNT - 1 + SAMPLE_OFS);
  localparam logic [CW-1:0]    C_BIT_LAST  = CW'(BAUD_COUNT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(FRAME_BITS - 1);

  uart_rx_state_t r_state;
  logic [CW-1:0]    r_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_framing_err;
  logic             r_busy;
  logic             w_rx_s;
  logic             w_sample;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rx),
    .o_q (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = majority3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_framing_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_framing_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == C_START_DEC) begin
            r_cnt <= '0;
            if (!w_sample) begin
              r_bit_idx <= '0;
              r_state   <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_sample, r_shift[7:1]};
            if (r_bit_idx == C_IDX_LAST) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Leaving at mid-stop-bit leaves half a bit of margin for a back-to-back start edge.
        STOP: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt <= '0;
            if (w_sample) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data        = r_data;
  assign bus.valid       = r_valid;
  assign bus.framing_err = r_framing_err;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_in_mod.sv
// Scoreboard bench for uart_rx_in_mod at a reduced clock so one bit is 32 clocks.
// Builds either way; the glitch-filter frame expects a different byte when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx_in_mod;

  localparam int CLOCK_FREQ = 3_686_400;
  localparam int BAUD_RATE  = 115200;
  localparam int BAUD       = 32;
  localparam int HALF       = 16;
  localparam int LATENCY    = 2 + HALF + 9 * BAUD;
  localparam int LAT_TOL    = 2;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
    int         fallCycle;
  } expect_t;

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   errors;
  expect_t expQ[$];

  uart_rx_in_mod_if bus ();

  uart_rx_in_mod #(
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_FREQ(CLOCK_FREQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; the glitch inverts each data bit for the one cycle the plain receiver samples.
  task automatic applyStimulus(input logic [7:0] b, input int stopCycles, input logic stopLevel,
                               input bit glitch, input logic expErr, input logic [7:0] expData);
    expect_t e;
    e.isErr     = expErr;
    e.data      = expData;
    e.fallCycle = cycle;
    expQ.push_back(e);
    bus.rx = 1'b0;
    waitCycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (glitch) begin
        waitCycles(HALF);
        bus.rx = ~b[i];
        waitCycles(1);
        bus.rx = b[i];
        waitCycles(BAUD - HALF - 1);
      end else begin
        waitCycles(BAUD);
      end
    end
    bus.rx = stopLevel;
    waitCycles(stopCycles);
    bus.rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.valid || bus.framing_err)) begin
      expect_t e;
      int lat;
      if (bus.valid && bus.framing_err) begin
        checks++;
        errors++;
        $display("[TB] FAIL pulse_overlap: valid and framing_err both high at cycle %0d", cycle);
      end
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: valid=%0b framing_err=%0b data=0x%0h, none expected",
                 bus.valid, bus.framing_err, bus.data);
      end else begin
        e = expQ.pop_front();
        lat = cycle - e.fallCycle;
        checkOutput("pulse_kind_ferr", 32'(bus.framing_err), 32'(e.isErr));
        checkOutput("rx_data", 32'(bus.data), 32'(e.data));
        checks++;
        if (lat < LATENCY - LAT_TOL || lat > LATENCY + LAT_TOL) begin
          errors++;
          $display("[TB] FAIL latency: got %0d cycles expected %0d +/- %0d", lat, LATENCY, LAT_TOL);
        end
        if (bus.valid) checkOutput("busy_at_valid", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] resetByte;
    logic [7:0] glitchExp;
    int drain;
    cycle  = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.rx = 1'b1;
    waitCycles(5);
    checkOutput("reset_data", 32'(bus.data), 32'h00);
    checkOutput("reset_valid", 32'(bus.valid), 32'd0);
    checkOutput("reset_ferr", 32'(bus.framing_err), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    waitCycles(20);

    $display("[TB] frame 0xA5");
    applyStimulus(8'hA5, BAUD, 1'b1, 1'b0, 1'b0, 8'hA5);
    waitCycles(20);

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, BAUD, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(8'hFF, BAUD, 1'b1, 1'b0, 1'b0, 8'hFF);
    waitCycles(20);

    $display("[TB] short low glitch on idle line");
    bus.rx = 1'b0;
    waitCycles(10);
    checkOutput("glitch_busy_high", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    waitCycles(15);
    checkOutput("glitch_busy_low", 32'(bus.busy), 32'd0);
    waitCycles(40);

    $display("[TB] 0x3C with long low stop, then 0x96");
    applyStimulus(8'h3C, 200, 1'b0, 1'b0, 1'b1, 8'hFF);
    waitCycles(8);
    applyStimulus(8'h96, BAUD, 1'b1, 1'b0, 1'b0, 8'h96);
    waitCycles(20);

    $display("[TB] reset during bit 4 of 0x81, then 0x42");
    resetByte = 8'h81;
    bus.rx = 1'b0;
    waitCycles(BAUD);
    for (int i = 0; i < 4; i++) begin
      bus.rx = resetByte[i];
      waitCycles(BAUD);
    end
    bus.rx = resetByte[4];
    waitCycles(HALF);
    rst = 1'b1;
    bus.rx = 1'b1;
    waitCycles(2);
    checkOutput("midreset_data", 32'(bus.data), 32'h00);
    checkOutput("midreset_valid", 32'(bus.valid), 32'd0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    waitCycles(20);
    applyStimulus(8'h42, BAUD, 1'b1, 1'b0, 1'b0, 8'h42);
    waitCycles(20);

    $display("[TB] 0x55 with mid-bit glitches");
`ifdef UART_RX_MAJORITY_EN
    glitchExp = 8'h55;
`else
    glitchExp = 8'hAA;
`endif
    applyStimulus(8'h55, BAUD, 1'b1, 1'b1, 1'b0, glitchExp);

    drain = 0;
    while (expQ.size() != 0 && drain < 2000) begin
      waitCycles(1);
      drain++;
    end
    waitCycles(50);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("final_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
